// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: mem-op field layout,
// access size codes, FSM state encodings and bus-width constants.
// Pure declarations; no logic and no latency of its own.
package mem_stage_pkg;

  // Register/data bus width and its all-zero value.
  localparam int REG_BUS = 64;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  // Field positions inside the 5-bit mem-op code.
  localparam int MEM_OP_ACCESS   = 4;
  localparam int MEM_OP_STORE    = 3;
  localparam int MEM_OP_UNSIGNED = 2;
  localparam int MEM_OP_SIZE_HI  = 1;
  localparam int MEM_OP_SIZE_LO  = 0;

  // Access size codes.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // Natural alignment: the low address bits covered by the size must be zero.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    logic ok;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = (off[0] == 1'b0);
      SIZE_W:  ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  // Byte-strobe pattern for a lane-0 access of the given size.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SIZE_B:  m = 8'h01;
      SIZE_H:  m = 8'h03;
      SIZE_W:  m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Lane steering for the data-memory port: store strobes/data and load extract+extend.
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are used.
module mem_stage_lsu_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [5:0]      lane_shift;
  logic [XLEN-1:0] lane;
  logic            sext;

  assign lane_shift = {off, 3'b000};

  // Store side: strobes and data both move up to the addressed byte lane.
  always_comb begin
    wstrb = size_mask(size) << off;
    wdata = store_data << lane_shift;
  end

  // Load side: bring the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    lane      = rdata >> lane_shift;
    sext      = 1'b0;
    load_data = lane;
    case (size)
      SIZE_B: begin
        sext      = ~is_unsigned & lane[7];
        load_data = {{(XLEN-8){sext}}, lane[7:0]};
      end
      SIZE_H: begin
        sext      = ~is_unsigned & lane[15];
        load_data = {{(XLEN-16){sext}}, lane[15:0]};
      end
      SIZE_W: begin
        sext      = ~is_unsigned & lane[31];
        load_data = {{(XLEN-32){sext}}, lane[31:0]};
      end
      default: begin
        sext      = 1'b0;
        load_data = lane;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches execute result, runs loads/stores on dmem, feeds write-back.
// Latency: 1 cycle for non-memory ops, 3 cycles minimum for loads/stores (req, resp, out).
// Backpressure: ex_ready only in IDLE or when the OUT beat retires; req and wb beats held until ready.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_rd_data,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_mem_op,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_rd_wen,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_wen,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [7:0]      dmem_req_wstrb,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd_addr,
  output logic            wb_rd_wen,
  output logic [XLEN-1:0] wb_rd_data,
  output logic            mem_misalign
);

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [1:0]      accept_target;
  logic            accept;
  logic            ex_access;
  logic            ex_aligned;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] store_data_q;
  logic [4:0]      mem_op_q;
  logic [4:0]      rd_addr_q;
  logic            rd_wen_q;
  logic [XLEN-1:0] rd_data_q;
  logic            misalign_q;

  logic            is_store;
  logic [7:0]      wstrb_raw;
  logic [XLEN-1:0] wdata_raw;
  logic [XLEN-1:0] load_data;

  assign ex_ready   = (state == ST_IDLE) || (state == ST_OUT && wb_ready);
  assign accept     = ex_valid && ex_ready;
  assign ex_access  = ex_mem_op[MEM_OP_ACCESS];
  assign ex_aligned = is_aligned(ex_mem_op[MEM_OP_SIZE_HI:MEM_OP_SIZE_LO], ex_rd_data[2:0]);

  // Misaligned accesses never touch memory; they report straight to write-back.
  assign accept_target = (ex_access && ex_aligned) ? ST_REQ : ST_OUT;

  assign is_store = mem_op_q[MEM_OP_ACCESS] & mem_op_q[MEM_OP_STORE];

  mem_stage_lsu_align #(.XLEN(XLEN)) u_align (
    .size        (mem_op_q[MEM_OP_SIZE_HI:MEM_OP_SIZE_LO]),
    .is_unsigned (mem_op_q[MEM_OP_UNSIGNED]),
    .off         (addr_q[2:0]),
    .store_data  (store_data_q),
    .rdata       (dmem_resp_rdata),
    .wstrb       (wstrb_raw),
    .wdata       (wdata_raw),
    .load_data   (load_data)
  );

  // Request fields come only from registered state, so they cannot move while REQ waits.
  assign dmem_req_valid = (state == ST_REQ);
  assign dmem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign dmem_req_wen   = is_store;
  assign dmem_req_wstrb = is_store ? wstrb_raw : 8'h00;
  assign dmem_req_wdata = is_store ? wdata_raw : ZERO_WORD;

  assign wb_valid     = (state == ST_OUT);
  assign wb_rd_addr   = rd_addr_q;
  assign wb_rd_wen    = rd_wen_q;
  assign wb_rd_data   = rd_data_q;
  assign mem_misalign = (state == ST_OUT) && misalign_q;

  // Next-state: a retiring OUT beat can hand over directly to a newly accepted op.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = accept_target;
      ST_REQ:  if (dmem_req_ready) state_next = ST_RESP;
      ST_RESP: if (dmem_resp_valid) state_next = ST_OUT;
      ST_OUT:  if (wb_ready) state_next = accept ? accept_target : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State and pipeline registers; results land in rd_data_q on accept (ALU) or response (load).
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      addr_q       <= ZERO_WORD;
      store_data_q <= ZERO_WORD;
      mem_op_q     <= 5'd0;
      rd_addr_q    <= 5'd0;
      rd_wen_q     <= 1'b0;
      rd_data_q    <= ZERO_WORD;
      misalign_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q       <= ex_rd_data;
        store_data_q <= ex_store_data;
        mem_op_q     <= ex_mem_op;
        rd_addr_q    <= ex_rd_addr;
        // Stores and faulting accesses never write the register file.
        rd_wen_q     <= ex_rd_wen && !(ex_access && (ex_mem_op[MEM_OP_STORE] || !ex_aligned));
        rd_data_q    <= ex_access ? ZERO_WORD : ex_rd_data;
        misalign_q   <= ex_access && !ex_aligned;
      end else if (state == ST_RESP && dmem_resp_valid) begin
        rd_data_q <= is_store ? ZERO_WORD : load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_rd_data;
  logic [63:0] ex_store_data;
  logic [4:0]  ex_mem_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_wen;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [63:0] dmem_req_addr;
  logic        dmem_req_wen;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_wstrb;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_wen;
  logic [63:0] wb_rd_data;
  logic        mem_misalign;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_rd_data      (ex_rd_data),
    .ex_store_data   (ex_store_data),
    .ex_mem_op       (ex_mem_op),
    .ex_rd_addr      (ex_rd_addr),
    .ex_rd_wen       (ex_rd_wen),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wen    (dmem_req_wen),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_wstrb  (dmem_req_wstrb),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_rdata (dmem_resp_rdata),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_rd_addr      (wb_rd_addr),
    .wb_rd_wen       (wb_rd_wen),
    .wb_rd_data      (wb_rd_data),
    .mem_misalign    (mem_misalign)
  );

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] rdata;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    logic [63:0] wb_data;
    logic        wb_wen;
    logic        mis;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid        = 1'b0;
    ex_rd_data      = '0;
    ex_store_data   = '0;
    ex_mem_op       = 5'd0;
    ex_rd_addr      = 5'd0;
    ex_rd_wen       = 1'b0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = '0;
    wb_ready        = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ex_ready"},  64'(ex_ready), 64'd1);
    chk({tag, " req_valid"}, 64'(dmem_req_valid), 64'd0);
    chk({tag, " wb_valid"},  64'(wb_valid), 64'd0);
    chk({tag, " misalign"},  64'(mem_misalign), 64'd0);
    chk({tag, " wb_rd_wen"}, 64'(wb_rd_wen), 64'd0);
    chk({tag, " req_wen"},   64'(dmem_req_wen), 64'd0);
    chk({tag, " req_addr"},  dmem_req_addr, 64'd0);
    chk({tag, " wstrb"},     64'(dmem_req_wstrb), 64'd0);
    chk({tag, " wdata"},     dmem_req_wdata, 64'd0);
    chk({tag, " wb_data"},   wb_rd_data, 64'd0);
    chk({tag, " wb_addr"},   64'(wb_rd_addr), 64'd0);
  endtask

  // One complete access with zero-wait memory, checking request and write-back beats.
  task automatic run_vec(input vec_t v);
    ex_valid = 1'b1; ex_mem_op = v.op; ex_rd_data = v.addr; ex_store_data = v.sdata;
    ex_rd_addr = 5'd9; ex_rd_wen = 1'b1; dmem_req_ready = 1'b1; wb_ready = 1'b0;
    #1 chk({v.name, " ex_ready"}, 64'(ex_ready), 64'd1);
    tick();
    ex_valid = 1'b0;
    if (!v.mis) begin
      #1;
      chk({v.name, " req_valid"}, 64'(dmem_req_valid), 64'd1);
      chk({v.name, " req_addr"},  dmem_req_addr, v.req_addr);
      chk({v.name, " req_wen"},   64'(dmem_req_wen), 64'(v.req_wen));
      chk({v.name, " wstrb"},     64'(dmem_req_wstrb), 64'(v.wstrb));
      chk({v.name, " wdata"},     dmem_req_wdata, v.wdata);
      chk({v.name, " wb_valid early"}, 64'(wb_valid), 64'd0);
      tick();
      dmem_req_ready = 1'b0;
      dmem_resp_valid = 1'b1; dmem_resp_rdata = v.rdata;
      #1 chk({v.name, " req_valid in resp"}, 64'(dmem_req_valid), 64'd0);
      tick();
      dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    end else begin
      #1 chk({v.name, " no req"}, 64'(dmem_req_valid), 64'd0);
    end
    #1;
    chk({v.name, " wb_valid"}, 64'(wb_valid), 64'd1);
    if (!v.mis) chk({v.name, " wb_data"}, wb_rd_data, v.wb_data);
    chk({v.name, " wb_wen"},   64'(wb_rd_wen), 64'(v.wb_wen));
    chk({v.name, " misalign"}, 64'(mem_misalign), 64'(v.mis));
    chk({v.name, " wb_addr"},  64'(wb_rd_addr), 64'd9);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    #1 chk({v.name, " wb_valid after"}, 64'(wb_valid), 64'd0);
    chk({v.name, " misalign after"}, 64'(mem_misalign), 64'd0);
  endtask

  initial begin
    //        name        op        addr      sdata                  rdata                  req_addr  wen wstrb  wdata                  wb_data                wb_wen mis
    vecs[0]  = '{"LB",    5'b10000, 64'h1003, 64'h0,                 64'h00000000_80000000, 64'h1000, 0, 8'h00, 64'h0,                 64'hFFFFFFFF_FFFFFF80, 1, 0};
    vecs[1]  = '{"LBU",   5'b10100, 64'h1003, 64'h0,                 64'h00000000_80000000, 64'h1000, 0, 8'h00, 64'h0,                 64'h00000000_00000080, 1, 0};
    vecs[2]  = '{"SH",    5'b11001, 64'h2006, 64'hABCD,              64'h0,                 64'h2000, 1, 8'hC0, 64'hABCD0000_00000000, 64'h0,                 0, 0};
    vecs[3]  = '{"LWmis", 5'b10010, 64'h3002, 64'h0,                 64'h0,                 64'h0,    0, 8'h00, 64'h0,                 64'h0,                 0, 1};
    vecs[4]  = '{"LD",    5'b10011, 64'h4008, 64'h0,                 64'h01234567_89ABCDEF, 64'h4008, 0, 8'h00, 64'h0,                 64'h01234567_89ABCDEF, 1, 0};
    vecs[5]  = '{"LH",    5'b10001, 64'h5002, 64'h0,                 64'h00000000_80010000, 64'h5000, 0, 8'h00, 64'h0,                 64'hFFFFFFFF_FFFF8001, 1, 0};
    vecs[6]  = '{"LWU",   5'b10110, 64'h6004, 64'h0,                 64'hDEADBEEF_00000000, 64'h6000, 0, 8'h00, 64'h0,                 64'h00000000_DEADBEEF, 1, 0};
    vecs[7]  = '{"SW",    5'b11010, 64'h7004, 64'h11223344,          64'h0,                 64'h7000, 1, 8'hF0, 64'h11223344_00000000, 64'h0,                 0, 0};
    vecs[8]  = '{"SB",    5'b11000, 64'h7007, 64'hFFFFFFFF_FFFFFF5A, 64'h0,                 64'h7000, 1, 8'h80, 64'h5A000000_00000000, 64'h0,                 0, 0};
    vecs[9]  = '{"LHmis", 5'b10001, 64'h5001, 64'h0,                 64'h0,                 64'h0,    0, 8'h00, 64'h0,                 64'h0,                 0, 1};
    vecs[10] = '{"LW",    5'b10010, 64'h6000, 64'h0,                 64'h00000000_FFFFFFFE, 64'h6000, 0, 8'h00, 64'h0,                 64'hFFFFFFFF_FFFFFFFE, 1, 0};

    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1 chk_reset_outputs("reset");

    // ALU pass-through: three back-to-back ops, one per cycle.
    wb_ready = 1'b1; ex_valid = 1'b1; ex_mem_op = 5'b00000; ex_rd_addr = 5'd3; ex_rd_wen = 1'b1;
    ex_rd_data = 64'd5;
    tick();
    for (int i = 0; i < 3; i++) begin
      ex_rd_data = 64'd6 + 64'(i);
      if (i == 2) ex_valid = 1'b0;
      #1;
      chk("alu wb_valid", 64'(wb_valid), 64'd1);
      chk("alu wb_data", wb_rd_data, 64'd5 + 64'(i));
      chk("alu wb_wen", 64'(wb_rd_wen), 64'd1);
      chk("alu no req", 64'(dmem_req_valid), 64'd0);
      tick();
    end
    #1 chk("alu drained", 64'(wb_valid), 64'd0);
    idle_inputs();

    // Table of memory accesses.
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Request backpressure: LD held for 4 cycles, then write-back backpressure for 3 cycles.
    ex_valid = 1'b1; ex_mem_op = 5'b10011; ex_rd_data = 64'h8010; ex_rd_addr = 5'd7; ex_rd_wen = 1'b1;
    dmem_req_ready = 1'b0; wb_ready = 1'b0;
    tick();
    ex_valid = 1'b1; ex_mem_op = 5'b00000; ex_rd_data = 64'h55;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp req_valid", 64'(dmem_req_valid), 64'd1);
      chk("bp req_addr", dmem_req_addr, 64'h8010);
      chk("bp ex_ready", 64'(ex_ready), 64'd0);
      tick();
    end
    ex_valid = 1'b0;
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 64'hCAFEF00D_12345678;
    tick();
    dmem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wbbp wb_valid", 64'(wb_valid), 64'd1);
      chk("wbbp wb_data", wb_rd_data, 64'hCAFEF00D_12345678);
      chk("wbbp wb_addr", 64'(wb_rd_addr), 64'd7);
      chk("wbbp ex_ready", 64'(ex_ready), 64'd0);
      tick();
    end
    wb_ready = 1'b1;
    #1 chk("wbbp ex_ready on retire", 64'(ex_ready), 64'd1);
    tick();
    wb_ready = 1'b0;
    #1 chk("wbbp drained", 64'(wb_valid), 64'd0);

    // Reset while waiting in RESP, then a late response.
    ex_valid = 1'b1; ex_mem_op = 5'b10000; ex_rd_data = 64'h9001; ex_rd_addr = 5'd4; ex_rd_wen = 1'b1;
    dmem_req_ready = 1'b1;
    tick();
    ex_valid = 1'b0;
    tick();
    dmem_req_ready = 1'b0;
    #1 chk("rst in resp req_valid", 64'(dmem_req_valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk_reset_outputs("rst mid");
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 64'hFFFF;
    tick();
    dmem_resp_valid = 1'b0;
    #1 chk("late resp wb_valid", 64'(wb_valid), 64'd0);
    chk("late resp wb_data", wb_rd_data, 64'd0);
    tick();
    #1 chk("late resp wb_valid 2", 64'(wb_valid), 64'd0);
    idle_inputs();
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined RV64 core, sitting directly downstream of the execute stage and upstream of write-back. It latches the execute result, performs loads and stores on the data-memory port through a valid/ready request and response handshake, aligns and extends load data, and forwards the destination-register write to write-back. Non-memory instructions pass through with one cycle of latency.

## Interface
- `XLEN`, 64: datapath width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ex_valid` in 1: execute stage presents an instruction.
- `ex_ready` out 1: stage accepts it this cycle.
- `ex_rd_data` in XLEN: ALU result. For memory ops this is the byte address.
- `ex_store_data` in XLEN: store source (rs2), right-aligned.
- `ex_mem_op` in 5: memory-op code:
  - [4] access.
  - [3] store.
  - [2] unsigned load.
  - [1:0] size: 00 = B, 01 = H, 10 = W, 11 = D.
- `ex_rd_addr` in 5, `ex_rd_wen` in 1: destination register.
- `dmem_req_valid` out 1, `dmem_req_ready` in 1: request handshake.
- `dmem_req_addr` out XLEN: address with bits [2:0] forced to 0.
- `dmem_req_wen` out 1: write request.
- `dmem_req_wdata` out XLEN: write data, lane-shifted.
- `dmem_req_wstrb` out 8: byte strobes.
- `dmem_resp_valid` in 1, `dmem_resp_rdata` in XLEN: response. Stores also receive one response, used as the write acknowledge.
- `wb_valid` out 1, `wb_ready` in 1: write-back handshake.
- `wb_rd_addr` out 5, `wb_rd_wen` out 1, `wb_rd_data` out XLEN: result to write-back.
- `mem_misalign` out 1: qualifies the current `wb_valid` beat as a misaligned access.

## Operation
- FSM states: IDLE, REQ, RESP, OUT.
- `ex_ready` = (state == IDLE) || (state == OUT && `wb_ready`).
- On accept (`ex_valid && ex_ready`), register all ex_* inputs.
  - Non-access op: go to OUT.
  - Aligned access: go to REQ.
  - Misaligned access: go to OUT with `mem_misalign` = 1 and `wb_rd_wen` = 0.
- Alignment rule: H needs addr[0] = 0, W needs addr[1:0] = 0, D needs addr[2:0] = 0.
- REQ: `dmem_req_valid` = 1, all request fields held stable until `dmem_req_ready`, then go to RESP.
- RESP: wait for `dmem_resp_valid`, then go to OUT.
  - Load: select the lane at offset addr[2:0], sign-extend, or zero-extend when [2] = 1, and register the result into `wb_rd_data`.
  - Store: `wb_rd_data` = 0, `wb_rd_wen` = 0.
- OUT: `wb_valid` = 1, outputs held until `wb_ready`.
  - If `wb_ready` and a new accept occur in the same cycle, take the next state from the new instruction.
  - If `wb_ready` with no accept, go to IDLE.
- Store encoding:
  - `wstrb` = size mask (0x01, 0x03, 0x0F, 0xFF) shifted left by addr[2:0].
  - `wdata` = `ex_store_data` shifted left by 8·addr[2:0].
- `dmem_resp_valid` is ignored outside RESP.

## Timing
- Reset values:
  - state = IDLE.
  - `ex_ready` = 1.
  - `dmem_req_valid` = 0, `wb_valid` = 0, `mem_misalign` = 0, `wb_rd_wen` = 0, `dmem_req_wen` = 0.
  - All data, address and strobe outputs = 0.
- Reset mid-transaction abandons the access and returns to IDLE. A late response is ignored.
- Latency, counted from the accept edge:
  - Non-memory op: `wb_valid` the next cycle. Back-to-back throughput is 1 per cycle when `wb_ready` is held high.
  - Load or store with zero-wait memory: `dmem_req_valid` at +1, handshake at +1, response at +2 at the earliest, `wb_valid` at +3.
- A response is never taken in the same cycle as its request handshake.
- `dmem_req_valid` never drops before `dmem_req_ready`.
- `wb_valid` never drops before `wb_ready`.

## Structure
- `defines.v` holds:
  - `MEM_OP` field positions and the size codes.
  - State encodings.
  - `REG_BUS` and `ZERO_WORD`.
- Load-alignment and extend logic go in a combinational sub-module, `mem_stage_lsu_align`. It also produces `wstrb`/`wdata`.
- The FSM and pipeline registers live in `mem_stage`.

## Test plan
- ALU pass-through: three back-to-back non-memory ops with `wb_ready` = 1, `ex_rd_data` = 5, 6, 7 → `wb_valid` on consecutive cycles, `wb_rd_data` = 5, 6, 7, no dmem activity.
- LB sign-extend: addr 0x1003, resp rdata 0x00000000_80000000 → `dmem_req_addr` 0x1000, `wb_rd_data` 0xFFFF_FFFF_FFFF_FF80. The same access as LBU → 0x80.
- SH at addr 0x2006, data 0xABCD → `wstrb` 0xC0, `wdata` 0xABCD_0000_0000_0000, `wb_rd_wen` 0 after the ack.
- Backpressure:
  - `dmem_req_ready` low for 4 cycles → request fields stable and `ex_ready` 0 throughout.
  - `wb_ready` low for 3 cycles → `wb_*` held.
- Misaligned LW at 0x3002 → no `dmem_req_valid`, one `wb_valid` beat with `mem_misalign` = 1 and `wb_rd_wen` = 0.
- `rst` asserted while in RESP, then a response arrives → state IDLE, all outputs at reset values, response ignored, next op handled normally.
